// File: rtl/cjb_alu_result_stage_v_pkg.sv
// rtl/cjb_alu_result_stage_v_pkg.sv - shared cjbRISC flag definitions and reset constants
// Purpose: flag bit positions inside the {C,N,V,Z} status vector and the
// reset values used by the ALU result stage.
// Ports: none (package).
package cjb_alu_result_stage_v_pkg;

  localparam int NUM_FLAGS = 4;

  // Bit positions inside CNVZ vectors.
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam logic [NUM_FLAGS-1:0] CNVZ_RST = 4'b0000;
  localparam logic                 VALID_RST = 1'b0;

endpackage

// File: rtl/cjb_nbit_en_reg_v.sv
// rtl/cjb_nbit_en_reg_v.sv - N-bit enabled register with synchronous active-low reset
// Purpose: storage element for one field of a result-stage entry.
// Ports:
//   clk_i   - rising-edge clock
//   rstn_i  - synchronous active-low reset, loads RST_VAL
//   en_i    - load enable
//   d_i     - next value
//   q_o     - registered value
module cjb_nbit_en_reg_v #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      val_q <= RST_VAL;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/cjb_alu_result_stage_v.sv
// rtl/cjb_alu_result_stage_v.sv - ALU result write-back stage with status flag register
// Purpose: buffers ALU results towards the register file with a valid/ready
// handshake on both sides and maintains the architectural CNVZ status register,
// which is updated at accept time under a per-flag mask.
// Optional feature: define CJB_RESULT_SKID_EN to add a skid entry, giving full
// throughput under backpressure with In_Ready driven from registered state only.
// Ports:
//   Clock, Resetn            - clock, synchronous active-low reset
//   In_Valid / In_Ready      - input handshake
//   In_Result, In_Dest       - entry payload
//   In_CNVZ, In_Flag_Mask    - flags and per-flag update enables
//   Out_Valid / Out_Ready    - write-back handshake
//   Out_Result, Out_Dest     - write-back payload
//   CNVZ_Reg                 - status register
//   Busy                     - any entry held
module cjb_alu_result_stage_v
  import cjb_alu_result_stage_v_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DESTW = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Result,
  input  logic [3:0]       In_CNVZ,
  input  logic [3:0]       In_Flag_Mask,
  input  logic [DESTW-1:0] In_Dest,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Result,
  output logic [DESTW-1:0] Out_Dest,
  output logic [3:0]       CNVZ_Reg,
  output logic             Busy
);

  logic             accept;
  logic             retire;
  logic             main_v_q;
  logic             main_v_d;
  logic             main_load;
  logic [WIDTH-1:0] main_res_d;
  logic [DESTW-1:0] main_dest_d;
  logic             skid_v_q;

  assign accept = In_Valid & In_Ready;
  assign retire = main_v_q & Out_Ready;

`ifdef CJB_RESULT_SKID_EN
  logic             skid_v_d;
  logic             skid_load;
  logic             take_skid;
  logic [WIDTH-1:0] skid_res_q;
  logic [DESTW-1:0] skid_dest_q;

  // Depends only on registered state (and reset), never on Out_Ready.
  assign In_Ready = Resetn & ~skid_v_q;

  always_comb begin
    take_skid   = retire & skid_v_q;
    // Input goes to main when main is free now or being freed this cycle;
    // when skid is full no accept can happen, so take_skid has priority.
    main_load   = take_skid | (accept & (retire | ~main_v_q));
    skid_load   = accept & main_v_q & ~retire;
    main_res_d  = take_skid ? skid_res_q  : In_Result;
    main_dest_d = take_skid ? skid_dest_q : In_Dest;
    main_v_d    = main_load | (main_v_q & ~retire);
    skid_v_d    = skid_load | (skid_v_q & ~retire);
  end

  cjb_nbit_en_reg_v #(.WIDTH(1), .RST_VAL(VALID_RST)) u_skid_v (
    .clk_i(Clock), .rstn_i(Resetn), .en_i(1'b1), .d_i(skid_v_d), .q_o(skid_v_q)
  );
  cjb_nbit_en_reg_v #(.WIDTH(WIDTH)) u_skid_res (
    .clk_i(Clock), .rstn_i(Resetn), .en_i(skid_load), .d_i(In_Result), .q_o(skid_res_q)
  );
  cjb_nbit_en_reg_v #(.WIDTH(DESTW)) u_skid_dest (
    .clk_i(Clock), .rstn_i(Resetn), .en_i(skid_load), .d_i(In_Dest), .q_o(skid_dest_q)
  );
`else
  assign skid_v_q = 1'b0;

  // Single entry: a new result may replace one retiring in the same cycle.
  assign In_Ready = Resetn & (~main_v_q | Out_Ready);

  always_comb begin
    main_load   = accept;
    main_res_d  = In_Result;
    main_dest_d = In_Dest;
    main_v_d    = accept | (main_v_q & ~retire);
  end
`endif

  cjb_nbit_en_reg_v #(.WIDTH(1), .RST_VAL(VALID_RST)) u_main_v (
    .clk_i(Clock), .rstn_i(Resetn), .en_i(1'b1), .d_i(main_v_d), .q_o(main_v_q)
  );
  cjb_nbit_en_reg_v #(.WIDTH(WIDTH)) u_main_res (
    .clk_i(Clock), .rstn_i(Resetn), .en_i(main_load), .d_i(main_res_d), .q_o(Out_Result)
  );
  cjb_nbit_en_reg_v #(.WIDTH(DESTW)) u_main_dest (
    .clk_i(Clock), .rstn_i(Resetn), .en_i(main_load), .d_i(main_dest_d), .q_o(Out_Dest)
  );

  // One register per flag so unmasked flags simply hold their value.
  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    cjb_nbit_en_reg_v #(.WIDTH(1), .RST_VAL(CNVZ_RST[i])) u_flag (
      .clk_i (Clock),
      .rstn_i(Resetn),
      .en_i  (accept & In_Flag_Mask[i]),
      .d_i   (In_CNVZ[i]),
      .q_o   (CNVZ_Reg[i])
    );
  end

  assign Out_Valid = main_v_q;
  assign Busy      = main_v_q | skid_v_q;

endmodule

// File: doc/cjb_alu_result_stage_v.md
CJB_ALU_RESULT_STAGE_V -- requirements
Module: cjb_alu_result_stage_v

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ALU result width in bits.
REQ-002 SHALL have parameter DESTW, default 3, destination register address width.
REQ-003 SHALL have port Clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port Resetn  input  1  reset, synchronous, active-low, sampled on Clock rising edge.
REQ-005 SHALL have port In_Valid  input  1  ALU result presented.
REQ-006 SHALL have port In_Ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port In_Result  input  WIDTH  ALU result (arith/logic/shift/constant unit).
REQ-008 SHALL have port In_CNVZ  input  4  ALU flags {C,N,V,Z}.
REQ-009 SHALL have port In_Flag_Mask  input  4  per-flag update enable, same bit order as In_CNVZ.
REQ-010 SHALL have port In_Dest  input  DESTW  destination register address.
REQ-011 SHALL have port Out_Valid  output  1  write-back entry presented.
REQ-012 SHALL have port Out_Ready  input  1  register file accepts this cycle.
REQ-013 SHALL have port Out_Result  output  WIDTH  write-back data.
REQ-014 SHALL have port Out_Dest  output  DESTW  write-back address.
REQ-015 SHALL have port CNVZ_Reg  output  4  architectural status register.
REQ-016 SHALL have port Busy  output  1  high while any entry is held.

Function
REQ-017 SHALL define accept = In_Valid & In_Ready and retire = Out_Valid & Out_Ready, both evaluated in the same cycle.
REQ-018 SHALL, on accept, load CNVZ_Reg[i] from In_CNVZ[i] for each i with In_Flag_Mask[i]=1, holding other bits; flags update at accept, not retire.
REQ-019 SHALL leave CNVZ_Reg unchanged in cycles without accept, regardless of In_CNVZ.
REQ-020 SHALL hold entries (Result, Dest) in a main register driving Out_* and, with skid enabled, a second skid register.
REQ-021 SHALL drive Out_Valid from main-valid; Out_Result/Out_Dest stable while Out_Valid=1 and Out_Ready=0.
REQ-022 SHALL, with skid enabled, drive In_Ready = ~skid-valid, registered (no combinational path from Out_Ready).
REQ-023 SHALL, on retire with skid full: move skid to main, clear skid (no accept possible that cycle).
REQ-024 SHALL, on retire with skid empty: load main from input if accept, else clear main-valid.
REQ-025 SHALL, without retire: accept into main if main empty, else into skid.
REQ-026 SHALL preserve ordering: entries retire in accept order; none dropped or duplicated.
REQ-027 SHALL give latency of one cycle: an entry accepted into empty main appears on Out_* next cycle.
REQ-028 SHALL drive Busy = main-valid | skid-valid.
REQ-029 SHALL ignore In_* content when In_Valid=0 and Out_Ready when Out_Valid=0.

Reset
REQ-030 SHALL, while Resetn=0 at a clock edge, clear main-valid, skid-valid, CNVZ_Reg to 4'b0000, Out_Result and Out_Dest to zero.
REQ-031 SHALL drive In_Ready=0 during the reset cycle and In_Ready=1 on the first cycle after Resetn rises.
REQ-032 SHALL discard held entries on reset mid-operation; no partial retire.

Configuration
REQ-033 SHALL compile the skid register only when macro CJB_RESULT_SKID_EN is defined (throughput 1/cycle under backpressure, In_Ready registered).
REQ-034 SHALL, without CJB_RESULT_SKID_EN, use main only with In_Ready = ~main-valid | Out_Ready (combinational); flag behaviour unchanged.

Structure
REQ-035 SHALL place flag bit indices (C=3,N=2,V=1,Z=0) and reset constants in the shared cjbRISC definitions include.
REQ-036 SHALL implement each entry with one sub-module cjb_nbit_en_reg_v (enabled, synchronous active-low reset register), instantiated per field.

Verification
REQ-037 SHALL verify: reset then In_Valid=1, Result=8'hAA, Dest=3, Mask=4'b1111, CNVZ=4'b0100, Out_Ready=1 -> next cycle Out_Valid=1, Out_Result=8'hAA, Out_Dest=3, CNVZ_Reg=4'b0100.
REQ-038 SHALL verify: Mask=4'b0001, In_CNVZ=4'b1111 with CNVZ_Reg=4'b0100 -> CNVZ_Reg=4'b0101 after accept.
REQ-039 SHALL verify (skid): Out_Ready=0, send 8'h01 then 8'h02 -> In_Ready=0 after second accept; Out_Ready=1 -> 8'h01 then 8'h02 retire in order, In_Ready=1.
REQ-040 SHALL verify: continuous In_Valid=1 with Out_Ready=1, values 8'h00..8'hFF -> one retire per cycle, all 256 in order, CNVZ_Reg tracks last masked flags.
REQ-041 SHALL verify: two entries held, Resetn=0 one cycle -> Out_Valid=0, Busy=0, CNVZ_Reg=0, no retire of held entries.
REQ-042 SHALL verify (no skid): Out_Ready=0 with main full -> In_Ready=0; Out_Ready=1 same cycle as In_Valid=1 -> In_Ready=1, new entry replaces retired one.
